// File: rtl/ysyx_25060170_imem_resp.sv
// ysyx_25060170_imem_resp: IFU fetch responder backed by a preloadable word array with fixed latency
module ysyx_25060170_imem_resp #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]  state, state_d;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] mem [DEPTH];
  logic        accept, go_resp, rd_ok, wr_ok;
  logic [31:0] ld_addr, rd_idx, wr_idx;
  assign req_ready = rst && state == IDLE && !flush;
  assign rsp_valid = state == RESP;
  assign accept    = req_valid && req_ready;
  // with LATENCY==1 the load happens on the accept edge, before addr_q holds the address
  assign ld_addr = state == IDLE ? req_addr : addr_q;
  assign rd_idx  = (ld_addr - BASE_ADDR) >> 2;
  assign rd_ok   = ld_addr[1:0] == 2'b00 && ld_addr >= BASE_ADDR && rd_idx[31:AW] == '0;
  assign wr_idx  = (wr_addr - BASE_ADDR) >> 2;
  assign wr_ok   = wr_addr[1:0] == 2'b00 && wr_addr >= BASE_ADDR && wr_idx[31:AW] == '0;
  always_comb begin
    state_d = state == IDLE ? (accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
            : state == WAIT ? (flush ? IDLE : cnt == 4'd1 ? RESP : WAIT)
            : (flush || rsp_ready) ? IDLE : RESP;
    go_resp = state_d == RESP && state != RESP;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (go_resp) begin
        rsp_data <= rd_ok ? mem[rd_idx[AW-1:0]] : '0;
        rsp_err  <= !rd_ok;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_idx[AW-1:0]] <= wr_data;
  end
endmodule

// File: tb/tb_ysyx_25060170_imem_resp.sv
// tb_ysyx_25060170_imem_resp: scoreboard bench for the fetch responder
module tb_ysyx_25060170_imem_resp;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT   = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_err, rsp_ready = 1'b0, flush = 1'b0, wr_en = 1'b0;
  logic [31:0] req_addr = '0, rsp_data, wr_addr = '0, wr_data = '0;
  logic [31:0] model [DEPTH];
  logic [32:0] exp_q [$];
  int tests = 0, fails = 0;
  ysyx_25060170_imem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] expect_rsp(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00 || a < BASE || (off >> 2) >= DEPTH) return {1'b1, 32'h0};
    return {1'b0, model[off[11:2]]};
  endfunction
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    off = a - BASE;
    model[off[11:2]] = d;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask
  // wmode: 0 no write, 1 write on the accept edge, 2 write on the response-load edge
  task automatic do_fetch(input logic [31:0] a, input int hold, input int wmode, input logic [31:0] wd);
    int n;
    logic [32:0] e;
    logic [31:0] off, held;
    off = a - BASE;
    rsp_ready = (hold == 0);
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = a;
    if (wmode == 1) begin
      wr_en = 1'b1; wr_addr = a; wr_data = wd; model[off[11:2]] = wd;
    end
    exp_q.push_back(expect_rsp(a));
    if (wmode == 2) model[off[11:2]] = wd;
    @(posedge clk); #1 req_valid = 1'b0; wr_en = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (wmode == 2 && n == 1) begin
        wr_en = 1'b1; wr_addr = a; wr_data = wd;
      end else wr_en = 1'b0;
      if (rsp_valid || n >= 20) break;
    end
    wr_en = 1'b0;
    check("latency", 64'(n), 64'(LAT));
    if (exp_q.size() == 0) check("queue_empty", 64'd0, 64'd1);
    else begin
      e = exp_q.pop_front();
      check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
      check("rsp_err", 64'(rsp_err), 64'(e[32]));
    end
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data", 64'(rsp_data), 64'(held));
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", 64'(rsp_valid), 64'd0);
    check("post_hs_req_ready", 64'(req_ready), 64'd1);
  endtask
  initial begin
    #3;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    preload(BASE, 32'h0000_0413);
    preload(BASE + 32'd4, 32'hdead_beef);
    preload(BASE + 32'd8, 32'h1111_1111);
    preload(BASE + 32'hffc, 32'h0bad_f00d);
    @(negedge clk) rst = 1'b1;
    do_fetch(BASE, 0, 0, '0);
    do_fetch(BASE + 32'd4, 5, 0, '0);
    do_fetch(BASE + 32'hffc, 0, 0, '0);
    do_fetch(32'h8000_0002, 0, 0, '0);
    do_fetch(32'h7fff_fffc, 0, 0, '0);
    do_fetch(BASE + 32'(4 * DEPTH), 0, 0, '0);
    // flush during WAIT
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE + 32'd4;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_wait_valid", 64'(rsp_valid), 64'd0);
    check("flush_wait_req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("flush_wait_never", 64'(rsp_valid), 64'd0);
    // flush together with rsp_ready in RESP
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = BASE + 32'd4;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_resp_valid_before", 64'(rsp_valid), 64'd1);
    flush = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    check("flush_resp_valid", 64'(rsp_valid), 64'd0);
    check("flush_resp_req_ready", 64'(req_ready), 64'd1);
    // flush in IDLE blocks acceptance
    flush = 1'b1; req_valid = 1'b1; req_addr = BASE;
    #1 check("flush_idle_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_idle_no_rsp", 64'(rsp_valid), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    do_fetch(BASE + 32'd8, 0, 1, 32'h2222_2222);
    preload(BASE + 32'd8, 32'h1111_1111);
    do_fetch(BASE + 32'd8, 0, 2, 32'h2222_2222);
    do_fetch(BASE + 32'd8, 0, 0, '0);
    // asynchronous reset mid-WAIT
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE + 32'd4;
    @(posedge clk); #1 req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(rsp_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("arst_hold_valid", 64'(rsp_valid), 64'd0);
    check("arst_hold_data", 64'(rsp_data), 64'd0);
    rst = 1'b1;
    do_fetch(BASE, 0, 0, '0);
    do_fetch(BASE + 32'd4, 0, 0, '0);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
